// File: rtl/mips_bus_arb_pkg.sv
// Shared types for the fetch/data memory bus arbiter.
// States, bus owner encoding and the all-lanes byte enable.
package mips_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    DATA
  } owner_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mips_bus_arb_pick.sv
// Winner selection between fetch and data requesters.
// MIPS_BUS_ARB_FAIR_EN: ties alternate away from last_owner; else data wins.
module mips_bus_arb_pick
  import mips_bus_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output owner_t grant
);

`ifdef MIPS_BUS_ARB_FAIR_EN
  // Tie goes to whoever did not own the bus last
  always_comb begin
    grant = NONE;
    if (i_req && d_req)
      grant = (last_owner == DATA) ? FETCH : DATA;
    else if (d_req)
      grant = DATA;
    else if (i_req)
      grant = FETCH;
  end
`else
  logic unused_last;
  assign unused_last = ^last_owner;

  // Data always beats fetch
  always_comb begin
    grant = NONE;
    if (d_req)
      grant = DATA;
    else if (i_req)
      grant = FETCH;
  end
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// Serialises fetch and load/store traffic onto one Avalon-style bus.
// MIPS_BUS_ARB_FAIR_EN enables alternating tie-break via last_owner.
module mips_bus_arbiter
  import mips_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_waitrequest,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [3:0]        d_byteenable,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_waitrequest,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            grant;
  owner_t            last_owner;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              wr_q, wr_d;
  logic              d_req;
  logic              i_done;
  logic              d_done;

  assign d_req = d_read | d_write;

  mips_bus_arb_pick u_pick (
    .i_req      (i_read),
    .d_req      (d_req),
    .last_owner (last_owner),
    .grant      (grant)
  );

`ifdef MIPS_BUS_ARB_FAIR_EN
  owner_t last_q;

  // Remember each grant so the next tie goes the other way
  always_ff @(posedge clk) begin
    if (rst)
      last_q <= FETCH;
    else if (state_q == IDLE && grant != NONE)
      last_q <= grant;
  end

  assign last_owner = last_q;
`else
  assign last_owner = FETCH;
`endif

  // State and latched bus command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
    end
  end

  // Grant in IDLE, wait for acceptance in BUS, one-cycle RESP
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (grant == DATA) begin
          state_d = BUS;
          owner_d = DATA;
          addr_d  = d_address;
          wdata_d = d_writedata;
          be_d    = d_byteenable;
          wr_d    = d_write;
        end else if (grant == FETCH) begin
          state_d = BUS;
          owner_d = FETCH;
          addr_d  = i_address;
          wdata_d = '0;
          be_d    = BE_ALL;
          wr_d    = 1'b0;
        end
      end
      BUS: begin
        if (!waitrequest)
          state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        owner_d = NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  assign read       = (state_q == BUS) && !wr_q;
  assign write      = (state_q == BUS) && wr_q;
  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;

  assign i_done = (state_q == RESP) && (owner_q == FETCH);
  assign d_done = (state_q == RESP) && (owner_q == DATA);

  assign i_waitrequest = !i_done;
  assign d_waitrequest = !d_done;
  assign i_readdata    = i_done ? readdata : '0;
  assign d_readdata    = d_done ? readdata : '0;

endmodule
